mips_rtype_core: RTL
====================

Name: mips_rtype_core

Overview:
- Multi-cycle, clocked successor to the combinational R-type datapath.
- Accepts one 32-bit MIPS instruction per valid/ready handshake, then decodes it, reads the internal 32-entry register file, executes, and writes back to rd (R-type) or rt (I-type).
- Generalised in datapath width. Adds immediate ops, writeback, overflow and illegal-op flags, and a debug read port for verification.
- Sits between the instruction source (test sequencer or future fetch unit) and any result consumer.

Parameters:
- DATA_WIDTH, 32: register/ALU width. Must be >= 16. Instruction width stays fixed at 32.
- ZERO_REG, 1: 1 = register 0 reads as zero and ignores writes. 0 = register 0 is ordinary.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  core can accept an instruction.
- instruction  input  32  MIPS word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- result  output  DATA_WIDTH  ALU result of the last completed instruction.
- result_valid  output  1  one-cycle pulse when result is updated.
- ovf  output  1  signed overflow on the last completed instruction.
- illegal  output  1  unsupported opcode/funct on the last completed instruction.
- dbg_addr  input  5  debug register index.
- dbg_data  output  DATA_WIDTH  combinational read of register dbg_addr.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; all 32 registers=0; result=0; result_valid=0; ovf=0; illegal=0. instr_ready=1 from the first cycle after rst deasserts. Asserting rst mid-operation aborts the instruction with no writeback and no result_valid.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instruction and go to READ. instr_ready=0 in every other state.
  - READ: latch operand A = reg[rs] and operand B = reg[rt].
  - EXEC: ALU computes; latch result, overflow and illegal.
  - WB: write the destination unless suppressed; result_valid=1 for exactly this cycle; go to IDLE.
- Timing: accept at edge N gives result_valid high in cycle N+3. Throughput is one instruction per 4 cycles.
- Supported R-type ops (opcode 0x00), by funct:
  - add 0x20, addu 0x21, sub 0x22, subu 0x23.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A, sltu 0x2B.
  - sll 0x00, srl 0x02, sra 0x03: shift rt by shamt.
- Supported I-type ops: addi 0x08 (imm sign-extended to DATA_WIDTH), ori 0x0D (imm zero-extended). Destination is rt.
- Arithmetic is modulo 2^DATA_WIDTH. slt/sltu return 1 or 0, zero-extended.
- Shifts: shamt range 0..31. If shamt >= DATA_WIDTH, sll/srl give 0 and sra gives sign fill.
- Overflow: add, sub and addi with signed overflow set ovf=1 and suppress writeback; result still carries the wrapped value. addu/subu never flag.
- Illegal: any other opcode or funct sets illegal=1, forces result=0 and suppresses writeback. result_valid still pulses.
- ovf and illegal hold until the next WB.
- Register 0 with ZERO_REG=1: writes are dropped; reads and dbg_data return 0.
- Back-to-back dependency: a new instruction reads the register file after the previous WB edge, so it always sees the new value. No bypass is needed.
- instruction is ignored outside the IDLE handshake. instr_valid held high while busy has no effect.

Decomposition:
- Shared package mips_pkg: opcode and funct localparams (OP_RTYPE, OP_ADDI, OP_ORI, F_ADD … F_SRA) and the FSM state encoding.
- One sub-module, mips_rtype_alu: combinational. Inputs a, b, shamt, alu_op. Outputs y, ovf, illegal. Parametrised by DATA_WIDTH.
- The register file is a local array inside mips_rtype_core.

Test Plan:
- Reset, then ori $1,$0,0x1234: result_valid 3 cycles after accept, result=0x00001234, dbg reg1=0x1234, ovf=illegal=0.
- addi $2,$0,0xFFFB, then slt $3,$2,$1, then sltu $4,$2,$1, then sub $5,$1,$2: results 0xFFFFFFFB, 1, 0, 0x00001239.
- nor $6,$0,$0; srl $6,$6,1; add $7,$6,$6; addu $8,$6,$6: 0xFFFFFFFF, 0x7FFFFFFF, then ovf=1 with dbg reg7=0, then 0xFFFFFFFE with ovf=0.
- or $0,$1,$1 with ZERO_REG=1: result=0x1234, result_valid=1, dbg reg0 stays 0. sra $9,$2,4 gives 0xFFFFFFFF.
- funct 0x3F, then opcode 0x23: illegal=1, result=0, no register changes. Hold instr_valid high continuously: exactly one accept per 4 cycles.
- rst asserted during EXEC of ori $10,$0,0x55: no result_valid, dbg reg10=0, all registers 0, instr_ready=1 one cycle after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS R/I-type core: opcode and funct
// encodings, FSM states, ALU operation codes and the instruction decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SRA    = 6'h03;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_SLTU   = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_ADDU    = 4'd1,
        ALU_SUB     = 4'd2,
        ALU_SUBU    = 4'd3,
        ALU_AND     = 4'd4,
        ALU_OR      = 4'd5,
        ALU_XOR     = 4'd6,
        ALU_NOR     = 4'd7,
        ALU_SLT     = 4'd8,
        ALU_SLTU    = 4'd9,
        ALU_SLL     = 4'd10,
        ALU_SRL     = 4'd11,
        ALU_SRA     = 4'd12,
        ALU_ILLEGAL = 4'd13
    } alu_op_e;

    // Field view of a 32-bit instruction word; imm is {rd, shamt, funct}.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    // Map opcode/funct to an ALU operation; anything unsupported is ALU_ILLEGAL.
    // addi shares the checked adder with add so it flags signed overflow too.
    function automatic alu_op_e decode_op(input logic [5:0] opcode, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   op = ALU_ADD;
                    F_ADDU:  op = ALU_ADDU;
                    F_SUB:   op = ALU_SUB;
                    F_SUBU:  op = ALU_SUBU;
                    F_AND:   op = ALU_AND;
                    F_OR:    op = ALU_OR;
                    F_XOR:   op = ALU_XOR;
                    F_NOR:   op = ALU_NOR;
                    F_SLT:   op = ALU_SLT;
                    F_SLTU:  op = ALU_SLTU;
                    F_SLL:   op = ALU_SLL;
                    F_SRL:   op = ALU_SRL;
                    F_SRA:   op = ALU_SRA;
                    default: op = ALU_ILLEGAL;
                endcase
            end
            OP_ADDI: op = ALU_ADD;
            OP_ORI:  op = ALU_OR;
            default: op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

    // I-type instructions take their second operand from imm and write rt.
    function automatic logic is_itype(input logic [5:0] opcode);
        return (opcode == OP_ADDI) || (opcode == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_rtype_alu.sv
// Combinational ALU for the MIPS core: arithmetic, logic, compare and shifts,
// with signed-overflow and illegal-operation flags.
module mips_rtype_alu
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            shamt,
    input  alu_op_e               alu_op,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  ovf,
    output logic                  illegal
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_shift_oob;
    logic                  w_lt_signed;
    logic                  w_lt_unsigned;

    assign w_sum         = a + b;
    assign w_diff        = a - b;
    // shamt can reach 31, which exceeds the width when DATA_WIDTH is small.
    assign w_shift_oob   = (int'(shamt) >= DATA_WIDTH);
    assign w_lt_signed   = ($signed(a) < $signed(b));
    assign w_lt_unsigned = (a < b);

    // Select the result and flags for the requested operation.
    always_comb begin
        y       = {DATA_WIDTH{1'b0}};
        ovf     = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                y   = w_sum;
                ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            ALU_ADDU: y = w_sum;
            ALU_SUB: begin
                y   = w_diff;
                ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            ALU_SUBU: y = w_diff;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{MSB{1'b0}}, w_lt_signed};
            ALU_SLTU: y = {{MSB{1'b0}}, w_lt_unsigned};
            ALU_SLL: begin
                if (w_shift_oob) begin
                    y = {DATA_WIDTH{1'b0}};
                end else begin
                    y = b << shamt;
                end
            end
            ALU_SRL: begin
                if (w_shift_oob) begin
                    y = {DATA_WIDTH{1'b0}};
                end else begin
                    y = b >> shamt;
                end
            end
            ALU_SRA: begin
                if (w_shift_oob) begin
                    y = {DATA_WIDTH{b[MSB]}};
                end else begin
                    y = $unsigned($signed(b) >>> shamt);
                end
            end
            ALU_ILLEGAL: begin
                y       = {DATA_WIDTH{1'b0}};
                illegal = 1'b1;
            end
            default: begin
                y       = {DATA_WIDTH{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_rtype_core.sv
// Multi-cycle MIPS R/I-type core: accepts one instruction per handshake, then
// reads the internal register file, executes and writes back over four cycles.
module mips_rtype_core
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instruction,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  ovf,
    output logic                  illegal,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    state_e                r_state;
    instr_t                r_instr;
    logic [DATA_WIDTH-1:0] r_regs [32];
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_result_valid;
    logic                  r_ovf;
    logic                  r_illegal;
    logic                  r_ready;

    logic [15:0]           w_imm;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [DATA_WIDTH-1:0] w_rs_data;
    logic [DATA_WIDTH-1:0] w_rt_data;
    logic [DATA_WIDTH-1:0] w_op_b_src;
    logic                  w_itype;
    alu_op_e               w_alu_op;
    logic [4:0]            w_dest;
    logic                  w_wb_en;
    logic [DATA_WIDTH-1:0] w_alu_y;
    logic                  w_alu_ovf;
    logic                  w_alu_illegal;

    // The held instruction word drives decode for the whole READ..WB sequence.
    assign w_imm    = {r_instr.rd, r_instr.shamt, r_instr.funct};
    assign w_itype  = is_itype(r_instr.opcode);
    assign w_alu_op = decode_op(r_instr.opcode, r_instr.funct);
    assign w_dest   = w_itype ? r_instr.rt : r_instr.rd;

    // Register reads; register 0 is hard-wired to zero when enabled.
    assign w_rs_data = (ZERO_EN && (r_instr.rs == 5'd0)) ? {DATA_WIDTH{1'b0}} : r_regs[r_instr.rs];
    assign w_rt_data = (ZERO_EN && (r_instr.rt == 5'd0)) ? {DATA_WIDTH{1'b0}} : r_regs[r_instr.rt];
    assign dbg_data  = (ZERO_EN && (dbg_addr == 5'd0))   ? {DATA_WIDTH{1'b0}} : r_regs[dbg_addr];

    // Immediate extension: addi sign-extends, ori zero-extends.
    always_comb begin
        w_imm_ext = {DATA_WIDTH{1'b0}};
        if (r_instr.opcode == OP_ADDI) begin
            w_imm_ext = DATA_WIDTH'($signed(w_imm));
        end else begin
            w_imm_ext = DATA_WIDTH'(w_imm);
        end
    end

    assign w_op_b_src = w_itype ? w_imm_ext : w_rt_data;

    // Writeback is dropped on overflow, on illegal ops and for a hard-wired $0.
    assign w_wb_en = !r_ovf && !r_illegal && !(ZERO_EN && (w_dest == 5'd0));

    mips_rtype_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a       (r_op_a),
        .b       (r_op_b),
        .shamt   (r_instr.shamt),
        .alu_op  (w_alu_op),
        .y       (w_alu_y),
        .ovf     (w_alu_ovf),
        .illegal (w_alu_illegal)
    );

    // Control FSM with registered outputs and the register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_instr        <= '{default: '0};
            r_op_a         <= {DATA_WIDTH{1'b0}};
            r_op_b         <= {DATA_WIDTH{1'b0}};
            r_result       <= {DATA_WIDTH{1'b0}};
            r_result_valid <= 1'b0;
            r_ovf          <= 1'b0;
            r_illegal      <= 1'b0;
            r_ready        <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr <= instr_t'(instruction);
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_op_a  <= w_rs_data;
                    r_op_b  <= w_op_b_src;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result       <= w_alu_y;
                    r_ovf          <= w_alu_ovf;
                    r_illegal      <= w_alu_illegal;
                    r_result_valid <= 1'b1;
                    r_state        <= S_WB;
                end
                S_WB: begin
                    if (w_wb_en) begin
                        r_regs[w_dest] <= r_result;
                    end
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = r_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;
    assign illegal      = r_illegal;

endmodule
